// File: rtl/dmem_pkg.sv
// Shared constants, STAT bit layout and address-decode result type for the data-memory responder.
// The MMIO window (CNT/STAT) is compiled in only when DMEM_MMIO_EN is defined.
package dmem_pkg;

    localparam logic [31:0] DM_BASE_DEF   = 32'h1001_0000;
    localparam logic [31:0] MMIO_BASE_DEF = 32'h1001_F000;

    localparam logic [31:0] CNT_OFF  = 32'd0;
    localparam logic [31:0] STAT_OFF = 32'd4;

    localparam int RANGE_BIT    = 0;
    localparam int MISALIGN_BIT = 1;

    typedef enum logic [2:0] {
        HIT_RAM,
        HIT_CNT,
        HIT_STAT,
        ERR_MISALIGN,
        ERR_RANGE
    } dec_t;

    function automatic logic is_fault(input dec_t d);
        return (d == ERR_MISALIGN) || (d == ERR_RANGE);
    endfunction

endpackage

// File: rtl/dmem_mmio.sv
// MMIO register block: free-running cycle counter (CNT), sticky fault flags (STAT)
// and capture of the first faulting address. Built only with DMEM_MMIO_EN.
module dmem_mmio
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        req,
    input  logic        wr,
    input  dec_t        dec,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] cnt,
    output logic [31:0] stat,
    output logic        err,
    output logic [31:0] err_addr
);

    logic [1:0] sticky;
    logic [1:0] sticky_nxt;
    logic       fault;

    assign fault = req && is_fault(dec);

    // Clear is applied first so a same-cycle set of the same bit wins.
    always_comb begin
        sticky_nxt = sticky;
        if (req && wr && dec == HIT_STAT)
            sticky_nxt = sticky & ~wdata[1:0];
        if (req && dec == ERR_RANGE)
            sticky_nxt[RANGE_BIT] = 1'b1;
        if (req && dec == ERR_MISALIGN)
            sticky_nxt[MISALIGN_BIT] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            sticky   <= '0;
            err_addr <= '0;
        end else if (ena) begin
            if (req && wr && dec == HIT_CNT)
                cnt <= wdata;
            else
                cnt <= cnt + 32'd1;
            sticky <= sticky_nxt;
            if (fault && sticky == 2'b00)
                err_addr <= addr;
        end
    end

    assign stat = {30'b0, sticky};
    assign err  = |sticky;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle core: word RAM with combinational read,
// address decode and fault tracking. DMEM_MMIO_EN adds the CNT/STAT register window.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] DM_BASE    = DM_BASE_DEF,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        DM_ena,
    input  logic        DM_W,
    input  logic        DM_R,
    input  logic [31:0] DM_addr,
    input  logic [31:0] DM_wdata,
    output logic [31:0] DM_rdata,
    output logic        err,
    output logic [31:0] err_addr
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    logic [31:0]           mem [WORDS];
    logic [29:0]           word_off;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  req;
    dec_t                  dec;

    assign req      = DM_ena && (DM_R || DM_W);
    assign word_off = DM_addr[31:2] - DM_BASE[31:2];
    assign idx      = word_off[DEPTH_LOG2-1:0];

    // Misalignment is reported ahead of any range decision.
    always_comb begin
        dec = ERR_RANGE;
        if (DM_addr[1:0] != 2'b00)
            dec = ERR_MISALIGN;
        else if (DM_addr >= DM_BASE && word_off[29:DEPTH_LOG2] == '0)
            dec = HIT_RAM;
`ifdef DMEM_MMIO_EN
        else if (DM_addr == MMIO_BASE + CNT_OFF)
            dec = HIT_CNT;
        else if (DM_addr == MMIO_BASE + STAT_OFF)
            dec = HIT_STAT;
`endif
    end

    // RAM has no reset; rst only blocks a write landing on the same edge.
    always_ff @(posedge clk) begin
        if (!rst && ena && DM_ena && DM_W && dec == HIT_RAM)
            mem[idx] <= DM_wdata;
    end

`ifdef DMEM_MMIO_EN
    logic [31:0] cnt;
    logic [31:0] stat;

    dmem_mmio u_mmio (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .req      (req),
        .wr       (DM_W),
        .dec      (dec),
        .addr     (DM_addr),
        .wdata    (DM_wdata),
        .cnt      (cnt),
        .stat     (stat),
        .err      (err),
        .err_addr (err_addr)
    );
`else
    logic [1:0]  sticky;
    logic [31:0] err_addr_q;

    // Without the MMIO window the fault flags are invisible and only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky     <= '0;
            err_addr_q <= '0;
        end else if (ena && req && is_fault(dec)) begin
            if (sticky == 2'b00)
                err_addr_q <= DM_addr;
            if (dec == ERR_RANGE)
                sticky[RANGE_BIT] <= 1'b1;
            else
                sticky[MISALIGN_BIT] <= 1'b1;
        end
    end

    assign err      = |sticky;
    assign err_addr = err_addr_q;
`endif

    always_comb begin
        DM_rdata = '0;
        if (DM_ena && DM_R) begin
            case (dec)
                HIT_RAM:  DM_rdata = mem[idx];
`ifdef DMEM_MMIO_EN
                HIT_CNT:  DM_rdata = cnt;
                HIT_STAT: DM_rdata = stat;
`endif
                default:  DM_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized bench for dmem_responder against a behavioural model
// of RAM contents, cycle counter, sticky fault flags and first-fault address.
module tb_dmem_responder;

    localparam logic [31:0] DMB  = 32'h1001_0000;
    localparam logic [31:0] MMB  = 32'h1001_F000;
    localparam logic [31:0] LAST = 32'h1001_0FFC;

    localparam int K_RAM = 0, K_CNT = 1, K_STAT = 2, K_MIS = 3, K_RNG = 4;

    logic        clk = 1'b0;
    logic        rst, ena, DM_ena, DM_W, DM_R;
    logic [31:0] DM_addr, DM_wdata, DM_rdata, err_addr;
    logic        err;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .DM_ena   (DM_ena),
        .DM_W     (DM_W),
        .DM_R     (DM_R),
        .DM_addr  (DM_addr),
        .DM_wdata (DM_wdata),
        .DM_rdata (DM_rdata),
        .err      (err),
        .err_addr (err_addr)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] m_mem [logic [31:0]];
    logic [31:0] m_cnt;
    logic [1:0]  m_stat;
    logic [31:0] m_eaddr;
    logic [31:0] last_rdata;

    function automatic int kind(input logic [31:0] a);
        if (a[1:0] != 2'b00) return K_MIS;
        if (a >= DMB && a < DMB + 32'h1000) return K_RAM;
`ifdef DMEM_MMIO_EN
        if (a == MMB) return K_CNT;
        if (a == MMB + 32'd4) return K_STAT;
`endif
        return K_RNG;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rs, input logic e, input logic de, input logic w,
                        input logic r, input logic [31:0] a, input logic [31:0] d);
        int          k;
        logic        req;
        logic [1:0]  ns;
        logic [31:0] exp_rd;
        logic        known;
        rst = rs; ena = e; DM_ena = de; DM_W = w; DM_R = r; DM_addr = a; DM_wdata = d;
        #1;
        last_rdata = DM_rdata;
        k = kind(a);
        known  = 1'b1;
        exp_rd = 32'h0;
        if (de && r) begin
            case (k)
                K_RAM:  if (m_mem.exists(a)) exp_rd = m_mem[a]; else known = 1'b0;
                K_CNT:  exp_rd = m_cnt;
                K_STAT: exp_rd = {30'b0, m_stat};
                default: exp_rd = 32'h0;
            endcase
        end
        if (known) chk("rdata", DM_rdata, exp_rd);
        chk("err", {31'b0, err}, {31'b0, |m_stat});
        chk("err_addr", err_addr, m_eaddr);
        @(posedge clk);
        if (rs) begin
            m_cnt = 0; m_stat = 0; m_eaddr = 0;
        end else if (e) begin
            req = de && (r || w);
            ns  = m_stat;
            if (req && w && k == K_STAT) ns = ns & ~d[1:0];
            if (req && k == K_MIS) ns[1] = 1'b1;
            if (req && k == K_RNG) ns[0] = 1'b1;
            if (req && (k == K_MIS || k == K_RNG) && m_stat == 2'b00) m_eaddr = a;
            if (req && w && k == K_CNT) m_cnt = d; else m_cnt = m_cnt + 32'd1;
            if (req && w && k == K_RAM) m_mem[a] = d;
            m_stat = ns;
        end
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, a, 32'h0);
    endtask

    task automatic clear_faults();
`ifdef DMEM_MMIO_EN
        wr(MMB + 32'd4, 32'h3);
`else
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, DMB, 32'h0);
`endif
    endtask

    initial begin
        logic [31:0] a;
        int          sel;
        rst = 1'b1; ena = 1'b0; DM_ena = 1'b0; DM_W = 1'b0; DM_R = 1'b0;
        DM_addr = '0; DM_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        m_cnt = 0; m_stat = 0; m_eaddr = 0;
        rst = 1'b0;

        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
`ifdef DMEM_MMIO_EN
        rd(MMB + 32'd4);
        chk("rst_stat", last_rdata, 32'h0);
`endif

        for (int i = 0; i < 16; i++) wr(DMB + 32'(4 * i), $urandom);
        wr(LAST, $urandom);

        wr(DMB + 32'd4, 32'hDEAD_BEEF);
        rd(DMB + 32'd4);
        chk("wr_then_rd", last_rdata, 32'hDEAD_BEEF);
        rd(DMB);

        wr(DMB + 32'd8, 32'h1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, DMB + 32'd8, 32'h2);
        chk("rw_same_cycle_old", last_rdata, 32'h1);
        rd(DMB + 32'd8);
        chk("rw_next_cycle_new", last_rdata, 32'h2);

        wr(LAST, 32'hA5A5_5A5A);
        rd(LAST);
        chk("last_word", last_rdata, 32'hA5A5_5A5A);

        wr(DMB + 32'h1000, 32'h1234);
        rd(DMB + 32'h1000);
        chk("oor_rdata", last_rdata, 32'h0);
        chk("oor_err", {31'b0, err}, 32'h1);
        chk("oor_err_addr", err_addr, DMB + 32'h1000);
`ifdef DMEM_MMIO_EN
        rd(MMB + 32'd4);
        chk("oor_stat", last_rdata, 32'h1);
`endif
        clear_faults();
        chk("clear_err", {31'b0, err}, 32'h0);

        rd(DMB + 32'd2);
        chk("mis_rdata", last_rdata, 32'h0);
        chk("mis_err", {31'b0, err}, 32'h1);
        chk("mis_err_addr", err_addr, DMB + 32'd2);
        rd(DMB + 32'h2000);
        chk("err_addr_held", err_addr, DMB + 32'd2);
`ifdef DMEM_MMIO_EN
        rd(MMB + 32'd4);
        chk("stat_both", last_rdata, 32'h3);
        wr(MMB + 32'd4, 32'h3);
        rd(MMB + 32'd4);
        chk("stat_cleared", last_rdata, 32'h0);
        chk("stat_cleared_err", {31'b0, err}, 32'h0);

        wr(MMB, 32'hFFFF_FFFE);
        rd(MMB);
        rd(MMB);
        chk("cnt_ffff", last_rdata, 32'hFFFF_FFFF);
        rd(MMB);
        chk("cnt_wrap", last_rdata, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, MMB, 32'h0);
            chk("cnt_hold", last_rdata, 32'h1);
        end
`else
        clear_faults();
`endif

        rd(DMB + 32'd1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, MMB, 32'h5555_5555);
        chk("rst_wr_err", {31'b0, err}, 32'h0);
        chk("rst_wr_err_addr", err_addr, 32'h0);
`ifdef DMEM_MMIO_EN
        rd(MMB);
        chk("rst_wr_cnt", last_rdata, 32'h0);
        rd(MMB + 32'd4);
        chk("rst_wr_stat", last_rdata, 32'h0);
`endif
        rd(DMB + 32'd4);
        chk("ram_survives_rst", last_rdata, 32'hDEAD_BEEF);

        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: a = DMB + 32'(4 * $urandom_range(0, 15));
                3:       a = LAST;
                4:       a = DMB + 32'h1000;
                5:       a = DMB + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
                6:       a = MMB;
                7:       a = MMB + 32'd4;
                8:       a = MMB + 32'd8;
                default: a = $urandom & 32'hFFFF_FFFC;
            endcase
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom), a,
                 (sel == 7) ? 32'($urandom_range(0, 3)) : $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
